// File: rtl/bos_spi_slave_if.sv
// SPI pins between the BOS initialiser (master) and the chip stand-in (slave).
interface bos_spi_slave_if;
    logic sck;
    logic sdatai;
    logic n_cs;
    logic sdatao;

    modport master (output sck, output sdatai, output n_cs, input sdatao);
    modport slave  (input sck, input sdatai, input n_cs, output sdatao);
endinterface

// File: rtl/bos_spi_slave.sv
// BOS serial configuration port responder: 24-bit CPOL=0/CPHA=0 frames, oversampled in clk.
// state | meaning
// IDLE  | waiting for n_cs to fall, sdatao held low
// CMD   | shifting in w/r + 7-bit address (8 sck rises)
// DATA  | shifting in 16 data bits, shifting read data out on sck falls
// DONE  | 24 bits received, waiting for n_cs rise to commit or flag an overrun
module bos_spi_slave #(
    parameter int          NUM_REGS    = 8,
    parameter logic [13:0] RESET_VAL   = 14'd0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    bos_spi_slave_if.slave           spi,
    output logic                     wr_stb,
    output logic [6:0]               wr_addr,
    output logic [13:0]              wr_data,
    output logic                     frame_err,
    output logic [NUM_REGS*14-1:0]   regs_flat
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, ncs_sync;
    logic                   sck_d, ncs_d;
    logic                   sck_s, sdi_s, ncs_s;
    logic                   sck_rise, sck_fall, ncs_rise, ncs_fall;

    state_t       state;
    logic [4:0]   bitcnt;
    logic [13:0]  shift_reg;
    logic [13:0]  shift_next;
    logic [15:0]  tx;
    logic         rw;
    logic [6:0]   addr;
    logic         overrun;
    logic         sdatao_q;
    logic [13:0]  rd_val;
    logic         addr_ok;
    logic [13:0]  regs [NUM_REGS];

    // Synchronisers come out of reset at the bus idle levels so no spurious edge appears.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_sync <= '0;
            sdi_sync <= '0;
            ncs_sync <= '1;
            sck_d    <= 1'b0;
            ncs_d    <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi.sdatai};
            ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], spi.n_cs};
            sck_d    <= sck_s;
            ncs_d    <= ncs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign ncs_s    = ncs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ncs_rise = ncs_s & ~ncs_d;
    assign ncs_fall = ~ncs_s & ncs_d;

    assign shift_next = {shift_reg[12:0], sdi_s};
    assign addr_ok    = {25'd0, addr} < 32'(NUM_REGS);

    // Read mux on the address being completed this cycle; unimplemented addresses read 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_next[6:0] == 7'(i)) rd_val = regs[i];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shift_reg <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            addr      <= '0;
            overrun   <= 1'b0;
            sdatao_q  <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    sdatao_q <= 1'b0;
                    if (ncs_fall) begin
                        state     <= CMD;
                        bitcnt    <= '0;
                        shift_reg <= '0;
                        overrun   <= 1'b0;
                    end
                end
                CMD: begin
                    if (ncs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sck_rise) begin
                        shift_reg <= shift_next;
                        bitcnt    <= bitcnt + 5'd1;
                        if (bitcnt == 5'd7) begin
                            rw    <= shift_next[7];
                            addr  <= shift_next[6:0];
                            tx    <= shift_next[7] ? {2'b00, rd_val} : 16'h0000;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (ncs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        if (sck_rise) begin
                            shift_reg <= shift_next;
                            bitcnt    <= bitcnt + 5'd1;
                            if (bitcnt == 5'd23) state <= DONE;
                        end
                        // Drive on the falling edge so the master samples on the next rise.
                        if (sck_fall && rw) begin
                            sdatao_q <= tx[15];
                            tx       <= {tx[14:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    if (ncs_rise) begin
                        if (overrun) begin
                            frame_err <= 1'b1;
                        end else if (!rw && addr_ok) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr == 7'(i)) regs[i] <= shift_reg;
                            end
                            wr_stb  <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= shift_reg;
                        end
                        state <= IDLE;
                    end else if (sck_rise) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spi.sdatao = sdatao_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*14 +: 14] = regs[g];
    end

endmodule

// File: tb/tb_bos_spi_slave.sv
// Randomised frame bench for bos_spi_slave against a register-bank reference model.
module tb_bos_spi_slave;
    localparam int          NUM_REGS  = 8;
    localparam logic [13:0] RESET_VAL = 14'd0;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    bos_spi_slave_if spi ();
    logic                   wr_stb, frame_err;
    logic [6:0]             wr_addr;
    logic [13:0]            wr_data;
    logic [NUM_REGS*14-1:0] regs_flat;

    bos_spi_slave #(.NUM_REGS(NUM_REGS), .RESET_VAL(RESET_VAL), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .spi       (spi),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .regs_flat (regs_flat)
    );

    int n_chk = 0;
    int n_fail = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    logic [13:0] model [NUM_REGS];

    always @(negedge clk) begin
        if (n_rst) begin
            if (wr_stb) stb_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS*14-1:0] model_flat();
        logic [NUM_REGS*14-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*14 +: 14] = model[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = RESET_VAL;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master side: sdatai changes while sck is low, sdatao is sampled as sck rises.
    task automatic spi_frame(input logic [23:0] frame, input int nbits, input int half,
                             input int gap, output logic [15:0] rx, output logic cmd_quiet);
        rx = '0;
        cmd_quiet = 1'b1;
        spi.n_cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi.sdatai = (i < 24) ? frame[23-i] : 1'b1;
            tick(half);
            if (i < 8 && spi.sdatao !== 1'b0) cmd_quiet = 1'b0;
            rx = {rx[14:0], spi.sdatao};
            spi.sck = 1'b1;
            tick(half);
            spi.sck = 1'b0;
        end
        tick(half);
        spi.n_cs = 1'b1;
        spi.sdatai = 1'b0;
        tick(gap);
    endtask

    task automatic run_frame(input logic [23:0] frame, input int nbits, input int half, input int gap);
        int s0, e0, ai;
        logic [15:0] rx;
        logic quiet, in_range;
        logic [15:0] exp_rd;
        s0 = stb_cnt;
        e0 = err_cnt;
        spi_frame(frame, nbits, half, gap, rx, quiet);
        ai = int'(frame[22:16]);
        in_range = ai < NUM_REGS;
        if (nbits != 24) begin
            chk("bad_len_frame_err", 128'(err_cnt - e0), 128'(1));
            chk("bad_len_no_stb", 128'(stb_cnt - s0), 128'(0));
        end else begin
            chk("frame_err", 128'(err_cnt - e0), 128'(0));
            if (!frame[23]) begin
                chk("wr_stb_count", 128'(stb_cnt - s0), 128'(in_range ? 1 : 0));
                if (in_range) begin
                    model[ai] = frame[13:0];
                    chk("wr_addr", 128'(wr_addr), 128'(frame[22:16]));
                    chk("wr_data", 128'(wr_data), 128'(frame[13:0]));
                end
                chk("wr_miso_low", 128'(rx), 128'(0));
            end else begin
                exp_rd = in_range ? {2'b00, model[ai]} : 16'h0000;
                chk("rd_data", 128'(rx), 128'(exp_rd));
                chk("rd_cmd_miso_low", 128'(quiet), 128'(1));
                chk("rd_no_stb", 128'(stb_cnt - s0), 128'(0));
            end
        end
        chk("regs", 128'(regs_flat), 128'(model_flat()));
        chk("idle_miso", 128'(spi.sdatao), 128'(0));
    endtask

    initial begin
        int s0, e0, nb, r;
        logic [23:0] fr;
        logic [23:0] rst_frame;
        spi.sck = 1'b0;
        spi.sdatai = 1'b0;
        spi.n_cs = 1'b1;
        model_reset();
        tick(5);
        chk("rst_regs", 128'(regs_flat), 128'(model_flat()));
        chk("rst_wr_stb", 128'(wr_stb), 128'(0));
        chk("rst_frame_err", 128'(frame_err), 128'(0));
        chk("rst_wr_addr", 128'(wr_addr), 128'(0));
        chk("rst_wr_data", 128'(wr_data), 128'(0));
        chk("rst_sdatao", 128'(spi.sdatao), 128'(0));
        n_rst = 1'b1;
        tick(3);

        run_frame(24'h030F00, 24, 4, 8);
        run_frame(24'h830000, 24, 4, 8);
        run_frame({1'b0, 7'h50, 2'b00, 14'h1234}, 24, 4, 8);
        run_frame({1'b1, 7'h50, 16'h0000}, 24, 4, 8);
        run_frame(24'h025555, 20, 4, 8);
        run_frame(24'h02AAAA, 25, 4, 8);

        // Reset partway through a write frame.
        s0 = stb_cnt;
        rst_frame = 24'h013FFF;
        spi.n_cs = 1'b0;
        for (int i = 0; i < 12; i++) begin
            spi.sdatai = rst_frame[23-i];
            tick(4);
            spi.sck = 1'b1;
            tick(4);
            spi.sck = 1'b0;
        end
        tick(2);
        n_rst = 1'b0;
        tick(2);
        spi.n_cs = 1'b1;
        spi.sdatai = 1'b0;
        model_reset();
        tick(2);
        chk("midrst_regs", 128'(regs_flat), 128'(model_flat()));
        chk("midrst_sdatao", 128'(spi.sdatao), 128'(0));
        chk("midrst_no_stb", 128'(stb_cnt - s0), 128'(0));
        n_rst = 1'b1;
        tick(3);
        run_frame(24'h010001, 24, 4, 8);
        run_frame(24'h830000, 24, 5, 8);
        run_frame(24'h810000, 24, 5, 8);

        // Init-sequence burst with short n_cs gaps.
        s0 = stb_cnt;
        e0 = err_cnt;
        for (int k = 0; k < 10; k++) run_frame(24'h030F00, 24, 4, 7);
        chk("burst_stb_total", 128'(stb_cnt - s0), 128'(10));
        chk("burst_err_total", 128'(err_cnt - e0), 128'(0));

        for (int k = 0; k < 40; k++) begin
            fr[23]    = 1'($urandom_range(0, 1));
            fr[22:16] = ($urandom_range(0, 9) == 0) ? 7'h50 : 7'($urandom_range(0, 9));
            fr[15:14] = 2'($urandom_range(0, 3));
            fr[13:0]  = 14'($urandom);
            r = $urandom_range(0, 9);
            nb = (r == 0) ? 20 : (r == 1) ? 25 : 24;
            run_frame(fr, nb, $urandom_range(4, 6), $urandom_range(7, 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
